// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock activation FIFO (read and write sides).
// Contents:
//   ptr_width(depth) : pointer width for a FIFO of 'depth' entries.
//                      It is one bit wider than the address, so full and empty can be told apart.
//   bin2gray / gray2bin : pointer code conversions.
//   The conversions work on a 32-bit word. A narrower pointer is zero-extended on the
//   way in and truncated on the way out. Both conversions are width-agnostic under
//   zero extension, so one function pair serves every pointer width.
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of the Gray bits at and above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = gray;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// Bundle of the read-side FIFO control signals.
// Signal groups:
//   reader handshake : rd_en, rd_data, rd_valid, empty, almost_empty, rd_level, underflow
//   storage port     : mem_raddr, mem_rdata (mem_rdata is combinational at mem_raddr)
//   cross-domain     : wr_ptr_gray (unsynchronised, from the write side)
//                      rd_ptr_gray (to the write side)
// Modports:
//   master : the read controller
//   slave  : everything around it (reader, storage, write side)
interface async_fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 4
);

  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_W:0]       rd_level;
  logic                  underflow;
  logic [ADDR_W-1:0]     mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_W:0]       wr_ptr_gray;
  logic [ADDR_W:0]       rd_ptr_gray;

  modport master (
    input  rd_en, wr_ptr_gray, mem_rdata,
    output rd_data, rd_valid, empty, almost_empty, rd_level, underflow,
           mem_raddr, rd_ptr_gray
  );

  modport slave (
    output rd_en, wr_ptr_gray, mem_rdata,
    input  rd_data, rd_valid, empty, almost_empty, rd_level, underflow,
           mem_raddr, rd_ptr_gray
  );

endinterface

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into rd_clk.
// Ports:
//   rd_clk, rd_rstn : destination clock and asynchronous active-low reset (chain resets to 0)
//   d               : Gray pointer from the foreign domain
//   q               : synchronised pointer, STAGES rd_clk edges behind d
// Passing the whole bus through the chain is safe only because the source changes
// at most one bit per update.
module gray_ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             rd_clk,
  input  logic             rd_rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_p;

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock activation FIFO. It runs entirely in rd_clk.
// Ports:
//   rd_clk, rd_rstn : read clock and asynchronous active-low reset
//   bus (master)    : reader handshake, storage read port, and Gray pointers to/from the write side
// Function:
//   - Synchronises the write pointer and registers empty, almost_empty and the fill level.
//     All three are computed against the post-read pointer, so the last word sets empty
//     on the same edge that consumes it, and the level never goes negative.
//   - The level is conservative, because the synchronised write pointer lags the real one.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rstn,
  async_fifo_rd_ctrl_if.master bus
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0]      wr_gray_s;
  logic [PTR_W-1:0]      wr_bin_s;
  logic                  rd_fire;
  logic [PTR_W-1:0]      rd_ptr_bin_next;
  logic [PTR_W-1:0]      rd_gray_next;
  logic [PTR_W-1:0]      level_next;

  logic [PTR_W-1:0]      rd_ptr_bin_p1;
  logic [PTR_W-1:0]      rd_ptr_gray_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;
  logic                  empty_p1;
  logic                  aempty_p1;
  logic [PTR_W-1:0]      level_p1;
  logic                  underflow_p1;

  gray_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .rd_clk  (rd_clk),
    .rd_rstn (rd_rstn),
    .d       (bus.wr_ptr_gray),
    .q       (wr_gray_s)
  );

  // Stage p0: pointer arithmetic on the current pointer and the synchronised write side
  assign rd_fire         = bus.rd_en & ~empty_p1;
  assign rd_ptr_bin_next = rd_ptr_bin_p1 + PTR_W'(rd_fire);
  assign rd_gray_next    = PTR_W'(bin2gray(ptr_word_t'(rd_ptr_bin_next)));
  assign wr_bin_s        = PTR_W'(gray2bin(ptr_word_t'(wr_gray_s)));
  // Pointers are one bit wider than the address, so modular subtraction yields 0..FIFO_DEPTH.
  assign level_next      = wr_bin_s - rd_ptr_bin_next;

  // Stage p1: registered pointer, flags, level and read word
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      rd_ptr_bin_p1  <= '0;
      rd_ptr_gray_p1 <= '0;
      rd_data_p1     <= '0;
      vld_p1         <= 1'b0;
      empty_p1       <= 1'b1;
      aempty_p1      <= 1'b1;
      level_p1       <= '0;
      underflow_p1   <= 1'b0;
    end else begin
      rd_ptr_bin_p1  <= rd_ptr_bin_next;
      rd_ptr_gray_p1 <= rd_gray_next;
      empty_p1       <= (rd_gray_next == wr_gray_s);
      level_p1       <= level_next;
      aempty_p1      <= (level_next <= AEMPTY_LVL);
      vld_p1         <= rd_fire;
      underflow_p1   <= bus.rd_en & empty_p1;
      if (rd_fire) begin
        rd_data_p1 <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_raddr    = rd_ptr_bin_p1[ADDR_W-1:0];
  assign bus.rd_ptr_gray  = rd_ptr_gray_p1;
  assign bus.rd_data      = rd_data_p1;
  assign bus.rd_valid     = vld_p1;
  assign bus.empty        = empty_p1;
  assign bus.almost_empty = aempty_p1;
  assign bus.rd_level     = level_p1;
  assign bus.underflow    = underflow_p1;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Testbench for async_fifo_rd_ctrl (DEPTH=16, SYNC_STAGES=2, AEMPTY_THRESH=2).
// Structure:
//   - A table of per-cycle vectors covers the reset exit, underflow, empty latency and a single word.
//   - Drain sequences use a scoreboard queue of expected read words.
//   - A hand-written sequence covers asynchronous reset mid-burst.
module tb_async_fifo_rd_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PW    = 5;

  logic rd_clk = 1'b0;
  logic rd_rstn;

  always #5 rd_clk = ~rd_clk;

  async_fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  async_fifo_rd_ctrl #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .SYNC_STAGES   (2),
    .AEMPTY_THRESH (2)
  ) dut (
    .rd_clk  (rd_clk),
    .rd_rstn (rd_rstn),
    .bus     (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  assign bus.mem_rdata = mem[bus.mem_raddr];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb_q [$];

  typedef struct packed {
    logic          rd_en;
    logic [PW-1:0] wr_gray;
    logic          empty;
    logic          aempty;
    logic [PW-1:0] level;
    logic          valid;
    logic          uflow;
    logic [DW-1:0] data;
    logic [PW-1:0] rgray;
    logic [AW-1:0] raddr;
  } vec_t;

  vec_t vt [10];

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] g5(input int b);
    logic [PW-1:0] x;
    x = b[PW-1:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"},  bus.empty,        1);
    chk({tag, "_aempty"}, bus.almost_empty, 1);
    chk({tag, "_valid"},  bus.rd_valid,     0);
    chk({tag, "_rgray"},  bus.rd_ptr_gray,  0);
    chk({tag, "_data"},   bus.rd_data,      0);
    chk({tag, "_level"},  bus.rd_level,     0);
    chk({tag, "_uflow"},  bus.underflow,    0);
    chk({tag, "_raddr"},  bus.mem_raddr,    0);
  endtask

  task automatic do_reset();
    bus.rd_en       = 1'b0;
    bus.wr_ptr_gray = '0;
    rd_rstn         = 1'b0;
    tick();
    tick();
    rd_rstn = 1'b1;
    tick();
  endtask

  // Advance the write pointer one word per cycle, then let the synchroniser and flags settle.
  task automatic fill(input int from, input int to);
    for (int i = from + 1; i <= to; i++) begin
      bus.wr_ptr_gray = g5(i);
      tick();
    end
    repeat (3) tick();
  endtask

  // Read n words from 'avail' available, then 'extra' more read attempts against an empty FIFO.
  task automatic drain(input int n, input int avail, input int extra, input int base);
    int rd;
    int lvl;
    int p;
    logic [DW-1:0] exp;
    for (int k = 0; k < n + extra; k++) begin
      bus.rd_en = 1'b1;
      if (k < n) sb_q.push_back(mem[(base + k) % DEPTH]);
      tick();
      rd  = (k < n) ? k + 1 : n;
      lvl = avail - rd;
      p   = (base + rd) % 32;
      chk("drain_valid",  bus.rd_valid,     k < n);
      chk("drain_uflow",  bus.underflow,    k >= n);
      chk("drain_level",  bus.rd_level,     lvl);
      chk("drain_aempty", bus.almost_empty, lvl <= 2);
      chk("drain_empty",  bus.empty,        lvl == 0);
      chk("drain_raddr",  bus.mem_raddr,    p % DEPTH);
      chk("drain_rgray",  bus.rd_ptr_gray,  g5(p));
      if (bus.rd_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_pop: rd_valid with no expected word at t=%0t", $time);
        end else begin
          exp = sb_q.pop_front();
          chk("sb_rd_data", bus.rd_data, exp);
        end
      end
    end
  endtask

  // The read pointer must never change more than one Gray bit between rd_clk edges.
  logic [PW-1:0] gray_prev;
  always @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      gray_prev <= '0;
    end else begin
      assert ($countones(bus.rd_ptr_gray ^ gray_prev) <= 1)
      else begin
        errors++;
        $display("FAIL gray_step: got %0h after %0h at t=%0t", bus.rd_ptr_gray, gray_prev, $time);
      end
      gray_prev <= bus.rd_ptr_gray;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //        en   wr     emp   ae    lvl   vld   uf    data      rgray raddr
    vt[0] = '{1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 16'h0000, 5'd0, 4'd0};
    vt[1] = '{1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 16'h0000, 5'd0, 4'd0};
    vt[2] = '{1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 16'h0000, 5'd0, 4'd0};
    vt[3] = '{1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 16'h0000, 5'd0, 4'd0};
    vt[4] = '{1'b0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 16'h0000, 5'd0, 4'd0};
    vt[5] = '{1'b0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 16'h0000, 5'd0, 4'd0};
    vt[6] = '{1'b0, 5'd1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 16'h0000, 5'd0, 4'd0};
    vt[7] = '{1'b1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 16'hA5A5, 5'd1, 4'd1};
    vt[8] = '{1'b1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 16'hA5A5, 5'd1, 4'd1};
    vt[9] = '{1'b0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 16'hA5A5, 5'd1, 4'd1};

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 16'hA5A5;

    // Reset held while rd_en toggles
    rd_rstn         = 1'b0;
    bus.rd_en       = 1'b0;
    bus.wr_ptr_gray = '0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_en = i[0];
      tick();
      chk_reset_state("rst");
    end
    bus.rd_en = 1'b0;
    rd_rstn   = 1'b1;
    tick();
    chk_reset_state("rst_exit");

    // Underflow, empty latency and a single word
    for (int i = 0; i < 10; i++) begin
      bus.rd_en       = vt[i].rd_en;
      bus.wr_ptr_gray = vt[i].wr_gray;
      tick();
      chk($sformatf("vec%0d_empty", i),  bus.empty,        vt[i].empty);
      chk($sformatf("vec%0d_aempty", i), bus.almost_empty, vt[i].aempty);
      chk($sformatf("vec%0d_level", i),  bus.rd_level,     vt[i].level);
      chk($sformatf("vec%0d_valid", i),  bus.rd_valid,     vt[i].valid);
      chk($sformatf("vec%0d_uflow", i),  bus.underflow,    vt[i].uflow);
      chk($sformatf("vec%0d_data", i),   bus.rd_data,      vt[i].data);
      chk($sformatf("vec%0d_rgray", i),  bus.rd_ptr_gray,  vt[i].rgray);
      chk($sformatf("vec%0d_raddr", i),  bus.mem_raddr,    vt[i].raddr);
    end

    // Full drain of 16 words
    do_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    fill(0, 16);
    chk("full_level",  bus.rd_level,     16);
    chk("full_empty",  bus.empty,        0);
    chk("full_aempty", bus.almost_empty, 0);
    drain(16, 16, 2, 0);
    bus.rd_en = 1'b0;

    // Second fill up to pointer 32 (wraps to 0), drain across the address and pointer wrap
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0100 + DW'(i);
    fill(16, 32);
    chk("wrap_level", bus.rd_level, 16);
    chk("wrap_empty", bus.empty,    0);
    drain(16, 16, 1, 16);
    bus.rd_en = 1'b0;
    tick();
    chk("wrap_rgray_end", bus.rd_ptr_gray, 0);

    // Asynchronous reset in the middle of a burst
    do_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0200 + DW'(i);
    fill(0, 10);
    chk("mid_level", bus.rd_level, 10);
    drain(5, 10, 0, 0);
    bus.rd_en = 1'b1;
    #2;
    rd_rstn = 1'b0;
    #1;
    chk_reset_state("midrst");
    bus.wr_ptr_gray = '0;
    tick();
    chk_reset_state("midrst_hold");
    bus.rd_en = 1'b0;
    rd_rstn   = 1'b1;
    tick();
    chk_reset_state("midrst_exit");

    chk("sb_leftover", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
Read-side control half of the dual-clock activation FIFO in the convolution accelerator, running entirely in the rd_clk domain.
- Synchronises the write-side Gray pointer and derives empty, almost-empty and fill level.
- Generates the storage read address and registers the read word.
- Presents rd_data/empty to the downstream FIFO reader stage and returns its own Gray read pointer to the write side for full detection.

Parameters:
DATA_WIDTH, 16, width of one FIFO word
FIFO_DEPTH, 16, number of storage entries; power of two, >= 4
SYNC_STAGES, 2, flop stages synchronising wr_ptr_gray into rd_clk; >= 2
AEMPTY_THRESH, 2, almost_empty asserted when fill level <= this value
(derived localparam) ADDR_W = $clog2(FIFO_DEPTH); pointers are ADDR_W+1 bits

Ports:
rd_clk  input  1  read-domain clock
rd_rstn  input  1  asynchronous active-low reset, rd_clk domain
rd_en  input  1  read request from downstream reader
wr_ptr_gray  input  ADDR_W+1  write pointer, Gray coded, wr_clk domain (unsynchronised)
mem_rdata  input  DATA_WIDTH  combinational read data of storage at mem_raddr
mem_raddr  output  ADDR_W  storage read address
rd_ptr_gray  output  ADDR_W+1  registered Gray read pointer to write side
rd_data  output  DATA_WIDTH  registered read word
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle
empty  output  1  FIFO empty (registered)
almost_empty  output  1  level <= AEMPTY_THRESH (registered)
rd_level  output  ADDR_W+1  conservative fill level, 0..FIFO_DEPTH
underflow  output  1  one-cycle pulse: rd_en while empty

Behaviour:
Reset values (rd_rstn low, asynchronous): rd_ptr_bin = 0, rd_ptr_gray = 0, all sync flops = 0, rd_data = 0, rd_valid = 0, empty = 1, almost_empty = 1, rd_level = 0, underflow = 0.

Synchronisation and pointer arithmetic:
- wr_ptr_gray passes through SYNC_STAGES flops to give wr_gray_s; gray2bin(wr_gray_s) gives wr_bin_s.
- rd_fire = rd_en & ~empty. When rd_fire is high, rd_ptr_bin_next = rd_ptr_bin + 1 (mod 2^(ADDR_W+1)); otherwise it holds.
- rd_ptr_gray <= bin2gray(rd_ptr_bin_next). It changes in at most one bit per rd_clk.
- mem_raddr = rd_ptr_bin[ADDR_W-1:0], combinational from the current pointer.

Flags and level (registered on rd_clk):
- empty <= (bin2gray(rd_ptr_bin_next) == wr_gray_s).
- rd_level <= wr_bin_s - rd_ptr_bin_next, computed modulo 2^(ADDR_W+1).
- almost_empty <= (that same level <= AEMPTY_THRESH).

Read data path:
- On rd_fire: rd_data <= mem_rdata and rd_valid <= 1. Latency is one rd_clk from the accepting edge.
- With no fire: rd_valid <= 0 and rd_data holds its last value.

Boundary conditions:
- Empty-flag latency: a write-pointer change is visible as empty deassertion SYNC_STAGES+1 rd_clk edges later. Empty is pessimistic and never falsely deasserts.
- Underflow: rd_en & empty pulses underflow for one cycle. Pointer, rd_data and rd_valid are unaffected.
- Last word: reading the final word sets empty on the same edge the pointer advances. Back-to-back rd_en therefore produces no extra fire.
- Simultaneous write arrival and read: the level uses post-read rd_ptr_bin_next, so it never goes negative.
- Wrap-around: the pointer MSB toggles every FIFO_DEPTH reads; mem_raddr wraps from FIFO_DEPTH-1 to 0.
- Reset mid-operation: all state returns to reset values immediately, with no partial rd_valid. The write side must be reset in the same system reset event; pointer consistency is the system's responsibility.

Decomposition:
- Shared package async_fifo_pkg: bin2gray and gray2bin functions (parameterised width), plus a ptr_width(depth) constant function. The package is reused by the write-side controller.
- One sub-module, gray_ptr_sync: a SYNC_STAGES-deep, width-parameterised flop chain on rd_clk/rd_rstn, reset to 0.

Test Plan:
1. Reset: hold rd_rstn low, toggle rd_en -> empty=1, almost_empty=1, rd_valid=0, rd_ptr_gray=0, rd_data=0, rd_level=0, underflow=0.
2. Single word (DEPTH=16, SYNC=2): wr_ptr_gray 0->5'b00001, mem_rdata=16'hA5A5 -> empty=0 and rd_level=1 at the 3rd rd_clk edge. One-cycle rd_en -> next cycle rd_valid=1, rd_data=16'hA5A5, rd_ptr_gray=5'b00001, empty=1.
3. Underflow: rd_en=1 while empty=1 for 3 cycles -> underflow high for 3 cycles, rd_valid=0, mem_raddr stays 0.
4. Full drain: wr_ptr_gray=5'b11000 (bin 16) -> rd_level=16. Continuous rd_en, mem_rdata=address -> mem_raddr 0..15, rd_data 0..15 on 16 consecutive rd_valid pulses, almost_empty rises when level reaches 2, empty after the 16th read.
5. Wrap: second fill to bin 32 (gray 5'b10000 wraps to 0 -> drive 5'b00000 after 5'b11000 sequence) and drain -> mem_raddr wraps 15->0, rd_ptr_gray returns to 0. An assertion checks the single-bit Gray change on every edge.
6. Reset mid-burst: drop rd_rstn after 5 reads of a 10-word fill -> all outputs return to reset values in the same cycle, without waiting for rd_clk.
